custom_axil_mem_slave: RTL and testbench

AXI4-Lite subordinate that terminates the 32-bit peripheral-bus master port of the CVA5 core wrapper. It serves reads and writes from a small word-addressed register memory with byte-strobe writes and registered single-beat responses. It is the bench and SoC endpoint for exercising the core's AR/R/AW/W/B traffic without the full crossbar.

---
 rtl/custom_axil_pkg.sv | 19 +
 rtl/custom_axil_regfile.sv | 31 +++
 rtl/custom_axil_mem_slave.sv | 184 ++++++++++++++++++
 tb/tb_custom_axil_mem_slave.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/custom_axil_pkg.sv
// Shared types and response codes for the custom_axil_mem_slave AXI4-Lite endpoint.
package custom_axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    R_IDLE,
    R_RESP
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_HAVE_AW,
    W_HAVE_W,
    W_RESP
  } wr_state_t;

endpackage

// File: rtl/custom_axil_regfile.sv
// DEPTHx32 register memory: async clear, one byte-enable write port, combinational read port.
module custom_axil_regfile #(
  parameter int DEPTH = 16,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [31:0]      wdata,
  input  logic [3:0]       wstrb,
  input  logic [IDX_W-1:0] raddr,
  output logic [31:0]      rdata
);

  // One array per byte lane keeps each lane's write enable independent.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] lane_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) lane_q[i] <= '0;
      end else if (we && wstrb[gi]) begin
        lane_q[waddr] <= wdata[8*gi +: 8];
      end
    end

    assign rdata[8*gi +: 8] = lane_q[raddr];
  end

endmodule

// File: rtl/custom_axil_mem_slave.sv
// AXI4-Lite register-memory subordinate with independent read and write FSMs.
// Optional out-of-range SLVERR reporting: define CUSTOM_AXIL_RANGE_CHECK_EN.
module custom_axil_mem_slave
  import custom_axil_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic [31:0]       s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  input  logic [31:0]       s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  output logic [1:0]        s_axi_bresp
);

  localparam int IDX_W = $clog2(DEPTH);

  rd_state_t         rd_state_q, rd_state_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;
  wr_state_t         wr_state_q, wr_state_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              alive_q;

  logic              ar_hs, aw_hs, w_hs;
  logic              commit;
  logic [ADDR_W-1:0] commit_addr;
  logic [31:0]       commit_data;
  logic [3:0]        commit_strb;
  logic              rd_in_range, wr_in_range;
  logic [31:0]       rf_rdata;
  logic              unused_addr_bits;

  // Readies stay low through reset and rise on the first edge after release.
  assign s_axi_arready = alive_q && (rd_state_q == R_IDLE);
  assign s_axi_rvalid  = (rd_state_q == R_RESP);
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_awready = alive_q && ((wr_state_q == W_IDLE) || (wr_state_q == W_HAVE_W));
  assign s_axi_wready  = alive_q && ((wr_state_q == W_IDLE) || (wr_state_q == W_HAVE_AW));
  assign s_axi_bvalid  = (wr_state_q == W_RESP);
  assign s_axi_bresp   = bresp_q;

  assign ar_hs = s_axi_arvalid && s_axi_arready;
  assign aw_hs = s_axi_awvalid && s_axi_awready;
  assign w_hs  = s_axi_wvalid && s_axi_wready;

`ifdef CUSTOM_AXIL_RANGE_CHECK_EN
  assign rd_in_range      = (s_axi_araddr[ADDR_W-1:IDX_W+2] == '0);
  assign wr_in_range      = (commit_addr[ADDR_W-1:IDX_W+2] == '0);
  assign unused_addr_bits = ^{s_axi_araddr[1:0], commit_addr[1:0]};
`else
  assign rd_in_range      = 1'b1;
  assign wr_in_range      = 1'b1;
  assign unused_addr_bits = ^{s_axi_araddr[ADDR_W-1:IDX_W+2], s_axi_araddr[1:0],
                              commit_addr[ADDR_W-1:IDX_W+2], commit_addr[1:0]};
`endif

  custom_axil_regfile #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_regfile (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (commit && wr_in_range),
    .waddr (commit_addr[2 +: IDX_W]),
    .wdata (commit_data),
    .wstrb (commit_strb),
    .raddr (s_axi_araddr[2 +: IDX_W]),
    .rdata (rf_rdata)
  );

  always_comb begin
    rd_state_d = rd_state_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    case (rd_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          rdata_d    = rd_in_range ? rf_rdata : 32'h0;
          rresp_d    = rd_in_range ? RESP_OKAY : RESP_SLVERR;
          rd_state_d = R_RESP;
        end
      end
      R_RESP: begin
        if (s_axi_rready) rd_state_d = R_IDLE;
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  // The commit port takes each half from the wire or the latch, whichever arrived last.
  always_comb begin
    wr_state_d  = wr_state_q;
    awaddr_d    = awaddr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    bresp_d     = bresp_q;
    commit      = 1'b0;
    commit_addr = awaddr_q;
    commit_data = wdata_q;
    commit_strb = wstrb_q;
    case (wr_state_q)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          commit      = 1'b1;
          commit_addr = s_axi_awaddr;
          commit_data = s_axi_wdata;
          commit_strb = s_axi_wstrb;
        end else if (aw_hs) begin
          awaddr_d   = s_axi_awaddr;
          wr_state_d = W_HAVE_AW;
        end else if (w_hs) begin
          wdata_d    = s_axi_wdata;
          wstrb_d    = s_axi_wstrb;
          wr_state_d = W_HAVE_W;
        end
      end
      W_HAVE_AW: begin
        if (w_hs) begin
          commit      = 1'b1;
          commit_data = s_axi_wdata;
          commit_strb = s_axi_wstrb;
        end
      end
      W_HAVE_W: begin
        if (aw_hs) begin
          commit      = 1'b1;
          commit_addr = s_axi_awaddr;
        end
      end
      W_RESP: begin
        if (s_axi_bready) wr_state_d = W_IDLE;
      end
      default: wr_state_d = W_IDLE;
    endcase
    if (commit) begin
      wr_state_d = W_RESP;
      bresp_d    = wr_in_range ? RESP_OKAY : RESP_SLVERR;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alive_q    <= 1'b0;
      rd_state_q <= R_IDLE;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
      wr_state_q <= W_IDLE;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bresp_q    <= RESP_OKAY;
    end else begin
      alive_q    <= 1'b1;
      rd_state_q <= rd_state_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      wr_state_q <= wr_state_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bresp_q    <= bresp_d;
    end
  end

endmodule

// File: tb/tb_custom_axil_mem_slave.sv
// Randomized self-checking bench for custom_axil_mem_slave against a transaction-level memory model.
module tb_custom_axil_mem_slave;

  localparam int DEPTH = 16;
`ifdef CUSTOM_AXIL_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        arvalid = 1'b0, arready, rvalid, rready = 1'b0;
  logic [31:0] araddr = '0, rdata;
  logic [1:0]  rresp, bresp;
  logic        awvalid = 1'b0, awready, wvalid = 1'b0, wready, bvalid, bready = 1'b0;
  logic [31:0] awaddr = '0, wdata = '0;
  logic [3:0]  wstrb = '0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  custom_axil_mem_slave #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axi_arvalid (arvalid),
    .s_axi_arready (arready),
    .s_axi_araddr  (araddr),
    .s_axi_rvalid  (rvalid),
    .s_axi_rready  (rready),
    .s_axi_rdata   (rdata),
    .s_axi_rresp   (rresp),
    .s_axi_awvalid (awvalid),
    .s_axi_awready (awready),
    .s_axi_awaddr  (awaddr),
    .s_axi_wvalid  (wvalid),
    .s_axi_wready  (wready),
    .s_axi_wdata   (wdata),
    .s_axi_wstrb   (wstrb),
    .s_axi_bvalid  (bvalid),
    .s_axi_bready  (bready),
    .s_axi_bresp   (bresp)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: memory contents plus which AXI phases are outstanding.
  logic [31:0] m_mem [DEPTH];
  bit          m_alive, m_rpend, m_awh, m_wh, m_bpend;
  bit          m_ar_hs, m_aw_hs, m_w_hs;
  logic [31:0] m_rdata, m_awaddr, m_wdata;
  logic [1:0]  m_rresp, m_bresp;
  logic [3:0]  m_wstrb;

  function automatic bit in_rng(input logic [31:0] a);
    return !RC || (a < DEPTH * 4);
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((a / 4) % DEPTH);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      m_alive = 0; m_rpend = 0; m_awh = 0; m_wh = 0; m_bpend = 0;
      m_rdata = '0; m_rresp = '0; m_bresp = '0;
    end else begin
      m_ar_hs = m_alive && !m_rpend && arvalid;
      m_aw_hs = m_alive && !m_bpend && !m_awh && awvalid;
      m_w_hs  = m_alive && !m_bpend && !m_wh && wvalid;
      if (m_rpend && rready) m_rpend = 0;
      if (m_bpend && bready) m_bpend = 0;
      if (m_ar_hs) begin
        m_rpend = 1;
        m_rdata = in_rng(araddr) ? m_mem[word_of(araddr)] : 32'h0;
        m_rresp = in_rng(araddr) ? 2'b00 : 2'b10;
      end
      if (m_aw_hs) begin m_awh = 1; m_awaddr = awaddr; end
      if (m_w_hs)  begin m_wh = 1; m_wdata = wdata; m_wstrb = wstrb; end
      if (m_awh && m_wh) begin
        if (in_rng(m_awaddr))
          for (int k = 0; k < 4; k++)
            if (m_wstrb[k]) m_mem[word_of(m_awaddr)][8*k +: 8] = m_wdata[8*k +: 8];
        m_bresp = in_rng(m_awaddr) ? 2'b00 : 2'b10;
        m_bpend = 1; m_awh = 0; m_wh = 0;
      end
      m_alive = 1;
    end
  end

  always @(negedge clk) begin
    chk("arready", {31'b0, arready}, {31'b0, m_alive && !m_rpend});
    chk("awready", {31'b0, awready}, {31'b0, m_alive && !m_bpend && !m_awh});
    chk("wready",  {31'b0, wready},  {31'b0, m_alive && !m_bpend && !m_wh});
    chk("rvalid",  {31'b0, rvalid},  {31'b0, m_rpend});
    chk("bvalid",  {31'b0, bvalid},  {31'b0, m_bpend});
    if (m_rpend) begin
      chk("rdata", rdata, m_rdata);
      chk("rresp", {30'b0, rresp}, {30'b0, m_rresp});
    end
    if (m_bpend) chk("bresp", {30'b0, bresp}, {30'b0, m_bresp});
    if (!rst_n) begin
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_resps", {28'b0, rresp, bresp}, 32'h0);
    end
  end

  task automatic cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                    input logic [1:0] er);
    awvalid = 1; awaddr = a; wvalid = 1; wdata = d; wstrb = s;
    cycle();
    awvalid = 0; wvalid = 0; bready = 1;
    @(negedge clk);
    chk("wr_bvalid", {31'b0, bvalid}, 32'h1);
    chk("wr_bresp", {30'b0, bresp}, {30'b0, er});
    cycle();
    bready = 0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] ed, input logic [1:0] er);
    arvalid = 1; araddr = a;
    cycle();
    arvalid = 0; rready = 1;
    @(negedge clk);
    chk("rd_rvalid", {31'b0, rvalid}, 32'h1);
    chk("rd_rdata", rdata, ed);
    chk("rd_rresp", {30'b0, rresp}, {30'b0, er});
    cycle();
    rready = 0;
  endtask

  initial begin
    repeat (3) cycle();
    chk("rst_readies", {29'b0, arready, awready, wready}, 32'h0);
    rst_n = 1;
    cycle();
    @(negedge clk);
    chk("post_rst_readies", {29'b0, arready, awready, wready}, 32'h7);
    cycle();

    wr(32'h08, 32'hDEADBEEF, 4'hF, 2'b00);
    rd(32'h08, 32'hDEADBEEF, 2'b00);

    // Data ahead of address; the response follows the address by one cycle.
    wvalid = 1; wdata = 32'h11223344; wstrb = 4'b0101;
    cycle();
    wvalid = 0;
    cycle(); cycle();
    awvalid = 1; awaddr = 32'h0C;
    @(negedge clk);
    chk("w_first_no_b", {31'b0, bvalid}, 32'h0);
    cycle();
    awvalid = 0; bready = 1;
    @(negedge clk);
    chk("w_first_bvalid", {31'b0, bvalid}, 32'h1);
    cycle();
    bready = 0;
    rd(32'h0C, 32'h00220044, 2'b00);

    arvalid = 1; araddr = 32'h08;
    awvalid = 1; awaddr = 32'h10; wvalid = 1; wdata = 32'h0BADF00D; wstrb = 4'hF;
    cycle();
    arvalid = 0; awvalid = 0; wvalid = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valids", {30'b0, rvalid, bvalid}, 32'h3);
      chk("bp_readies", {29'b0, arready, awready, wready}, 32'h0);
      chk("bp_rdata", rdata, 32'hDEADBEEF);
      chk("bp_bresp", {30'b0, bresp}, 32'h0);
      cycle();
    end
    rready = 1; bready = 1;
    cycle();
    rready = 0; bready = 0;

    wr(32'h04, 32'hAAAAAAAA, 4'hF, 2'b00);
    arvalid = 1; araddr = 32'h04;
    awvalid = 1; awaddr = 32'h04; wvalid = 1; wdata = 32'h55555555; wstrb = 4'hF;
    cycle();
    arvalid = 0; awvalid = 0; wvalid = 0; rready = 1; bready = 1;
    @(negedge clk);
    chk("coll_old_data", rdata, 32'hAAAAAAAA);
    chk("coll_bvalid", {31'b0, bvalid}, 32'h1);
    cycle();
    rready = 0; bready = 0;
    rd(32'h04, 32'h55555555, 2'b00);

    wr(32'h00, 32'h12345678, 4'hF, 2'b00);
    wr(32'h08, 32'hFFFFFFFF, 4'h0, 2'b00);
    rd(32'h08, 32'hDEADBEEF, 2'b00);
    if (RC) begin
      wr(32'h40, 32'hCAFEF00D, 4'hF, 2'b10);
      rd(32'h00, 32'h12345678, 2'b00);
      rd(32'h40, 32'h00000000, 2'b10);
    end else begin
      wr(32'h40, 32'hCAFEF00D, 4'hF, 2'b00);
      rd(32'h00, 32'hCAFEF00D, 2'b00);
      rd(32'h40, 32'hCAFEF00D, 2'b00);
    end

    awvalid = 1; awaddr = 32'h14; wvalid = 1; wdata = 32'h77777777; wstrb = 4'hF;
    cycle();
    awvalid = 0; wvalid = 0;
    @(negedge clk);
    chk("pre_rst_bvalid", {31'b0, bvalid}, 32'h1);
    #1 rst_n = 0;
    #1 chk("async_rst_bvalid", {31'b0, bvalid}, 32'h0);
    cycle(); cycle();
    rst_n = 1;
    cycle();
    @(negedge clk);
    chk("rerst_readies", {29'b0, arready, awready, wready}, 32'h7);
    cycle();
    for (int i = 0; i < DEPTH; i++) rd(32'(i * 4), 32'h0, 2'b00);

    for (int n = 0; n < 1500; n++) begin
      arvalid = ($urandom_range(0, 2) != 0);
      awvalid = ($urandom_range(0, 2) != 0);
      wvalid  = ($urandom_range(0, 2) != 0);
      rready  = ($urandom_range(0, 3) != 0);
      bready  = ($urandom_range(0, 3) != 0);
      araddr  = $urandom_range(0, 127);
      awaddr  = $urandom_range(0, 127);
      wdata   = $urandom;
      wstrb   = 4'($urandom_range(0, 15));
      cycle();
    end
    arvalid = 0; awvalid = 0; wvalid = 0; rready = 1; bready = 1;
    repeat (4) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
